// File: rtl/fwd_hazard_scoreboard.sv
// Destination-register scoreboard for DEPTH post-decode stages: picks the youngest forwarding
// source for every decode operand and raises a load-use stall with a saturating stall counter.
module fwd_hazard_scoreboard #(
    parameter int unsigned DEPTH      = 3,
    parameter int unsigned AW         = 5,
    parameter int unsigned NUM_SRC    = 2,
    parameter int unsigned LOAD_READY = 2,
    localparam int unsigned SELW      = $clog2(DEPTH + 1)
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic                      i_id_valid,
    input  logic                      i_id_reg_write,
    input  logic                      i_id_mem_read,
    input  logic [AW-1:0]             i_id_reg_dest,
    input  logic [NUM_SRC*AW-1:0]     i_id_src_addr,
    input  logic [NUM_SRC-1:0]        i_id_src_used,
    input  logic                      i_flush,
    input  logic                      i_stall_ext,
    output logic [NUM_SRC*SELW-1:0]   o_fwd_sel,
    output logic                      o_stall,
    output logic [15:0]               o_stall_count
);

    // Index 0 is stage 1 (EX); index DEPTH-1 is the oldest tracked stage.
    logic [DEPTH-1:0] r_v;
    logic [DEPTH-1:0] r_w;
    logic [DEPTH-1:0] r_l;
    logic [AW-1:0]    r_d [DEPTH];
    logic [15:0]      r_stall_count;

    logic [NUM_SRC*SELW-1:0] w_fwd_sel;
    logic [NUM_SRC-1:0]      w_hazard;
    logic                    w_stall;
    logic                    w_bubble;

    // Scan oldest to youngest so the youngest matching producer overwrites older ones.
    always_comb begin
        w_fwd_sel = '0;
        w_hazard  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (i_id_src_used[i] && r_v[k] && r_w[k]
                    && (r_d[k] == i_id_src_addr[i*AW +: AW])
                    && (i_id_src_addr[i*AW +: AW] != '0)) begin
                    w_fwd_sel[i*SELW +: SELW] = SELW'(k + 1);
                    w_hazard[i]               = r_l[k] && ((k + 1) < int'(LOAD_READY));
                end
            end
        end
    end

    assign w_stall  = i_id_valid && !i_flush && (|w_hazard);
    assign w_bubble = w_stall || i_flush || !i_id_valid;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_v           <= '0;
            r_w           <= '0;
            r_l           <= '0;
            r_stall_count <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                r_d[k] <= '0;
            end
        end else if (!i_stall_ext) begin
            for (int k = 1; k < DEPTH; k++) begin
                r_v[k] <= r_v[k-1];
                r_w[k] <= r_w[k-1];
                r_l[k] <= r_l[k-1];
                r_d[k] <= r_d[k-1];
            end
            r_v[0] <= !w_bubble;
            r_w[0] <= !w_bubble && i_id_reg_write;
            r_l[0] <= !w_bubble && i_id_mem_read;
            r_d[0] <= i_id_reg_dest;
            if (w_stall && (r_stall_count != 16'hFFFF)) begin
                r_stall_count <= r_stall_count + 16'd1;
            end
        end
    end

    assign o_fwd_sel     = w_fwd_sel;
    assign o_stall       = w_stall;
    assign o_stall_count = r_stall_count;

endmodule

// File: tb/tb_fwd_hazard_scoreboard.sv
// Scoreboard bench for fwd_hazard_scoreboard: three parameterisations share one stimulus set and
// each expected {FwdSel, Stall, StallCount} is queued when driven and checked mid-cycle.
module tb_fwd_hazard_scoreboard;

    logic        clk;
    logic        rst;
    logic        v;
    logic        rw;
    logic        mr;
    logic [4:0]  dest;
    logic [14:0] src;
    logic [2:0]  used;
    logic        fl;
    logic        ext;

    logic [3:0]  fwd0;
    logic        st0;
    logic [15:0] cnt0;
    logic [8:0]  fwd1;
    logic        st1;
    logic [15:0] cnt1;
    logic [7:0]  fwd2;
    logic        st2;
    logic [15:0] cnt2;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       tag;
        int          inst;
        logic [15:0] fwd;
        logic        stall;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb_q[$];

    fwd_hazard_scoreboard u_dut0 (
        .i_clock        (clk),
        .i_reset        (rst),
        .i_id_valid     (v),
        .i_id_reg_write (rw),
        .i_id_mem_read  (mr),
        .i_id_reg_dest  (dest),
        .i_id_src_addr  (src[9:0]),
        .i_id_src_used  (used[1:0]),
        .i_flush        (fl),
        .i_stall_ext    (ext),
        .o_fwd_sel      (fwd0),
        .o_stall        (st0),
        .o_stall_count  (cnt0)
    );

    fwd_hazard_scoreboard #(
        .DEPTH      (5),
        .AW         (5),
        .NUM_SRC    (3),
        .LOAD_READY (3)
    ) u_dut1 (
        .i_clock        (clk),
        .i_reset        (rst),
        .i_id_valid     (v),
        .i_id_reg_write (rw),
        .i_id_mem_read  (mr),
        .i_id_reg_dest  (dest),
        .i_id_src_addr  (src),
        .i_id_src_used  (used),
        .i_flush        (fl),
        .i_stall_ext    (ext),
        .o_fwd_sel      (fwd1),
        .o_stall        (st1),
        .o_stall_count  (cnt1)
    );

    // Every tracked stage counts as "not ready", so a self-dependent load stalls 15 of 16 cycles.
    fwd_hazard_scoreboard #(
        .DEPTH      (15),
        .AW         (5),
        .NUM_SRC    (2),
        .LOAD_READY (16)
    ) u_dut2 (
        .i_clock        (clk),
        .i_reset        (rst),
        .i_id_valid     (v),
        .i_id_reg_write (rw),
        .i_id_mem_read  (mr),
        .i_id_reg_dest  (dest),
        .i_id_src_addr  (src[9:0]),
        .i_id_src_used  (used[1:0]),
        .i_flush        (fl),
        .i_stall_ext    (ext),
        .o_fwd_sel      (fwd2),
        .o_stall        (st2),
        .o_stall_count  (cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [14:0] s3(input logic [4:0] a0, input logic [4:0] a1,
                                       input logic [4:0] a2);
        return {a2, a1, a0};
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        v   = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic step(input string tag, input int inst, input logic rst_in, input logic v_in,
                        input logic rw_in, input logic mr_in, input logic [4:0] dest_in,
                        input logic [14:0] src_in, input logic [2:0] used_in, input logic fl_in,
                        input logic ext_in, input logic [15:0] efwd, input logic estall,
                        input logic [15:0] ecnt);
        exp_t        e;
        logic [15:0] ofwd;
        logic        ostall;
        logic [15:0] ocnt;
        rst  = rst_in;
        v    = v_in;
        rw   = rw_in;
        mr   = mr_in;
        dest = dest_in;
        src  = src_in;
        used = used_in;
        fl   = fl_in;
        ext  = ext_in;
        sb_q.push_back('{tag: tag, inst: inst, fwd: efwd, stall: estall, cnt: ecnt});
        @(negedge clk);
        if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s scoreboard empty", tag);
        end else begin
            e = sb_q.pop_front();
            case (e.inst)
                0:       begin ofwd = 16'(fwd0); ostall = st0; ocnt = cnt0; end
                1:       begin ofwd = 16'(fwd1); ostall = st1; ocnt = cnt1; end
                default: begin ofwd = 16'(fwd2); ostall = st2; ocnt = cnt2; end
            endcase
            check({e.tag, ".fwd"}, ofwd, e.fwd);
            check({e.tag, ".stall"}, 16'(ostall), 16'(e.stall));
            check({e.tag, ".cnt"}, ocnt, e.cnt);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst  = 1'b0;
        v    = 1'b0;
        rw   = 1'b0;
        mr   = 1'b0;
        dest = '0;
        src  = '0;
        used = '0;
        fl   = 1'b0;
        ext  = 1'b0;

        // Default parameters: ALU chain, load-use, youngest wins, freeze, flush, reset.
        do_reset();
        step("rst_state", 0, 0, 1, 1, 0,  8, s3( 0,  0, 0), 3'b000, 0, 0, 16'h0, 0, 16'd0);
        step("alu_ex",    0, 0, 1, 1, 0,  9, s3( 8,  8, 0), 3'b011, 0, 0, 16'h5, 0, 16'd0);
        step("alu_mem",   0, 0, 1, 1, 0, 10, s3( 8,  0, 0), 3'b001, 0, 0, 16'h2, 0, 16'd0);
        step("lw_issue",  0, 0, 1, 1, 1,  8, s3(29,  0, 0), 3'b001, 0, 0, 16'h0, 0, 16'd0);
        step("lu_stall",  0, 0, 1, 1, 0,  9, s3( 8,  0, 0), 3'b011, 0, 0, 16'h1, 1, 16'd0);
        step("lu_fwd",    0, 0, 1, 1, 0,  9, s3( 8,  0, 0), 3'b011, 0, 0, 16'h2, 0, 16'd1);
        step("y_w5",      0, 0, 1, 1, 0,  5, s3( 0,  0, 0), 3'b000, 0, 0, 16'h0, 0, 16'd1);
        step("y_nowr",    0, 0, 1, 0, 0,  5, s3( 5,  0, 0), 3'b001, 0, 0, 16'h1, 0, 16'd1);
        step("y_w5b",     0, 0, 1, 1, 0,  5, s3( 5,  0, 0), 3'b001, 0, 0, 16'h2, 0, 16'd1);
        step("youngest",  0, 0, 1, 1, 0,  0, s3( 5,  0, 0), 3'b011, 0, 0, 16'h1, 0, 16'd1);
        step("zero_reg",  0, 0, 0, 0, 0,  0, s3( 0,  5, 0), 3'b011, 0, 0, 16'h8, 0, 16'd1);
        step("fz_lw",     0, 0, 1, 1, 1,  7, s3( 0,  0, 0), 3'b000, 0, 0, 16'h0, 0, 16'd1);
        for (int i = 0; i < 3; i++) begin
            step("freeze", 0, 0, 1, 1, 0,  9, s3( 7,  0, 0), 3'b001, 0, 1, 16'h1, 1, 16'd1);
        end
        step("fz_rel",    0, 0, 1, 1, 0,  9, s3( 7,  0, 0), 3'b001, 0, 0, 16'h1, 1, 16'd1);
        step("fz_fwd",    0, 0, 1, 1, 0,  9, s3( 7,  0, 0), 3'b001, 0, 0, 16'h2, 0, 16'd2);
        step("fl_lw",     0, 0, 1, 1, 1,  6, s3( 0,  0, 0), 3'b000, 0, 0, 16'h0, 0, 16'd2);
        step("flush",     0, 0, 1, 1, 0, 11, s3( 6,  0, 0), 3'b001, 1, 0, 16'h1, 0, 16'd2);
        step("fl_bubble", 0, 0, 1, 1, 0, 12, s3( 6, 11, 0), 3'b011, 0, 0, 16'h2, 0, 16'd2);
        step("rst_lw",    0, 0, 1, 1, 1, 13, s3( 0,  0, 0), 3'b000, 0, 0, 16'h0, 0, 16'd2);
        step("rst_hz",    0, 1, 1, 1, 0, 14, s3(13,  0, 0), 3'b001, 0, 0, 16'h1, 1, 16'd2);
        step("rst_clr",   0, 0, 1, 1, 0, 14, s3(13, 13, 0), 3'b011, 0, 0, 16'h0, 0, 16'd0);

        // DEPTH=5, NUM_SRC=3, LOAD_READY=3: two-cycle load-use and the stage-5 boundary.
        do_reset();
        step("p_lw",      1, 0, 1, 1, 1,  8, s3( 0,  0, 0), 3'b000, 0, 0, 16'h00, 0, 16'd0);
        step("p_st1",     1, 0, 1, 1, 0,  9, s3( 0,  0, 8), 3'b100, 0, 0, 16'h40, 1, 16'd0);
        step("p_st2",     1, 0, 1, 1, 0,  9, s3( 0,  0, 8), 3'b100, 0, 0, 16'h80, 1, 16'd1);
        step("p_go",      1, 0, 1, 1, 0,  9, s3( 0,  0, 8), 3'b100, 0, 0, 16'hC0, 0, 16'd2);
        step("p_prod",    1, 0, 1, 1, 0, 20, s3( 0,  0, 0), 3'b000, 0, 0, 16'h00, 0, 16'd2);
        for (int j = 1; j <= 4; j++) begin
            step("p_fill", 1, 0, 1, 1, 0, 21, s3(20,  0, 0), 3'b001, 0, 0, 16'(j), 0, 16'd2);
        end
        step("p_d5",      1, 0, 1, 0, 0,  0, s3( 0, 20, 0), 3'b010, 0, 0, 16'h28, 0, 16'd2);
        step("p_d6",      1, 0, 1, 0, 0,  0, s3(20,  0, 0), 3'b001, 0, 0, 16'h00, 0, 16'd2);

        // Self-dependent load repeated until StallCount saturates, then reset mid-hazard.
        do_reset();
        step("sat_t0",    2, 0, 1, 1, 1,  8, s3( 8,  0, 0), 3'b001, 0, 0, 16'h0, 0, 16'd0);
        repeat (69999) @(posedge clk);
        #1;
        step("sat_full",  2, 0, 1, 1, 1,  8, s3( 8,  0, 0), 3'b001, 0, 0, 16'h0, 0, 16'hFFFF);
        step("sat_hold",  2, 0, 1, 1, 1,  8, s3( 8,  0, 0), 3'b001, 0, 0, 16'h1, 1, 16'hFFFF);
        step("sat_rst",   2, 1, 1, 1, 1,  8, s3( 8,  0, 0), 3'b001, 0, 0, 16'h2, 1, 16'hFFFF);
        step("sat_clr",   2, 0, 1, 1, 1,  8, s3( 8,  0, 0), 3'b001, 0, 0, 16'h0, 0, 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_scoreboard.md
# fwd_hazard_scoreboard

Parametrised successor to the CPU's fixed forwarding unit and load-use hazard detector. It tracks the destination register of every in-flight instruction across DEPTH post-decode stages and, each cycle, gives every decode-stage source operand a forward-select code. It also raises a load-use stall and counts stall cycles. It sits beside the ID stage, and its outputs drive the ID/EX forwarding muxes, PC write enable and IF/ID write enable.

## Interface
- DEPTH, 3: number of tracked stages after ID. Stage 1 = EX, 2 = MEM, 3 = WB.
- AW, 5: register address width.
- NUM_SRC, 2: number of source operands checked per decoded instruction.
- LOAD_READY, 2: lowest stage index whose result bus carries load data.
- SELW, $clog2(DEPTH+1): width of each forward-select field (derived).
- Clock  in  1  pipeline clock.
- Reset  in  1  synchronous, active-high; clears all tracked state.
- ID_Valid  in  1  the decode slot holds a real instruction.
- ID_RegWrite  in  1  the decoded instruction writes a register.
- ID_MemRead  in  1  the decoded instruction is a load.
- ID_RegDest  in  AW  destination register of the decoded instruction.
- ID_SrcAddr  in  NUM_SRC*AW  source register addresses; operand i is at bits [i*AW +: AW].
- ID_SrcUsed  in  NUM_SRC  per-operand "actually read" flags.
- Flush  in  1  squash the decoded instruction (taken branch or jump).
- StallExt  in  1  external freeze, e.g. a memory wait.
- FwdSel  out  NUM_SRC*SELW  per operand: 0 = register file; k = result bus of stage k.
- Stall  out  1  load-use hazard; deassert PC and IF/ID write enables.
- StallCount  out  16  saturating count of cycles with Stall=1.

## Operation
- State per stage k (1..DEPTH): V[k], W[k], L[k], D[k] (valid, writes register, is load, destination).
- Match for operand i at stage k: ID_SrcUsed[i] & V[k] & W[k] & (D[k] == ID_SrcAddr[i]) & (ID_SrcAddr[i] != 0).
- FwdSel[i] = the smallest k that matches (youngest producer wins); 0 if no stage matches.
- Hazard for operand i: its youngest matching stage k has L[k]=1 and k < LOAD_READY.
- Stall = ID_Valid & ~Flush & (hazard on any operand). FwdSel is still driven during a stall and is don't-care to the consumer.
- Register update at posedge Clock, in priority order:
  - Reset: all V cleared, all W cleared, all L cleared, all D set to 0, StallCount set to 0.
  - else if StallExt: all stages hold; StallCount holds.
  - else advance:
    - Stage k+1 takes stage k for k = 1..DEPTH-1.
    - Stage DEPTH's old contents are discarded.
    - Stage 1 takes a bubble (V=0, W=0, L=0) if Stall | Flush | ~ID_Valid.
    - Otherwise stage 1 takes {1, ID_RegWrite, ID_MemRead, ID_RegDest}.
  - StallCount increments when Stall=1 and StallExt=0. It saturates at 16'hFFFF.
- An instruction with ID_RegWrite=0 enters a stage but never matches.
- Simultaneous Flush and hazard: Flush wins, so Stall=0 and a bubble is inserted.
- Simultaneous StallExt and hazard: Stall stays asserted and nothing advances.
- Reset mid-stall: Stall drops the cycle after Reset because all V are 0.

## Timing
- FwdSel and Stall are combinational from the stage registers and the ID inputs, in the same cycle. No added latency.
- Tracking latency: an instruction issued at edge n sits in stage 1 during cycle n+1, and in stage k during cycle n+k.
- A load followed immediately by a dependent instruction, with LOAD_READY=2: exactly 1 stall cycle. Forwarding then comes from stage 2.
- Reset values of outputs: FwdSel all 0, Stall 0, StallCount 0.
- With DEPTH=3, an instruction DEPTH+1 = 4 issues behind the producer sees FwdSel=0. It reads the register file, which writes on the first half-cycle.

## Test plan
- ALU chain: issue add $8, then add $9,$8,$8 -> FwdSel = {1,1}, Stall = 0. One instruction later, a user of $8 -> FwdSel = 2.
- Load-use: issue lw $8, then add $9,$8,$0 -> Stall = 1 for exactly 1 cycle and StallCount = 1. On the next cycle FwdSel[0] = 2 and Stall = 0.
- Youngest wins: stage 3 writes $5, then stage 1 writes $5; a source of $5 -> FwdSel = 1. A source of $0 written in stage 1 -> FwdSel = 0.
- Freeze and flush: load-use hazard with StallExt = 1 for 3 cycles -> stages hold, Stall = 1, StallCount unchanged. Flush = 1 with a pending hazard -> Stall = 0 and stage 1 takes a bubble.
- Parameter sweep: DEPTH = 5, NUM_SRC = 3, LOAD_READY = 3. A load followed by a dependent -> 2 stall cycles. A dependent 5 issues later -> FwdSel = 5; 6 issues later -> FwdSel = 0.
- Reset and saturation: hold a hazard for 70000 cycles -> StallCount = 16'hFFFF. Assert Reset in the middle of a hazard -> the next cycle has Stall = 0, StallCount = 0 and all FwdSel = 0.
